pmem_line_arbiter: RTL and testbench

Parametrised N-port physical-memory arbiter with integrated line/burst adaptor. Sits between the L1 caches (instruction, data, and any future prefetch or victim ports) and the single burst-oriented physical memory bus. It grants one cache-line transaction at a time using round-robin or fixed priority. It serialises line writes into bus beats and assembles bus beats into a full line for reads.

---
 rtl/pmem_line_arbiter.sv | 155 +++++++++++++++
 tb/tb_pmem_line_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_arbiter.sv
// pmem_line_arbiter: N-port cache-line arbiter with line-to-beat burst adaptor for one memory bus.
// Latency: burst starts the cycle after a request is seen in IDLE, resp pulses one cycle after the last beat.
// Backpressure: beats advance only on mem_resp; waiting ports hold their request until their req_resp.
module pmem_line_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_BITS = 256,
    parameter int BUS_BITS  = 64,
    parameter int ADDR_BITS = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req_read,
    input  logic [NUM_PORTS-1:0]           req_write,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_BITS-1:0] req_wdata,
    output logic [LINE_BITS-1:0]           req_rdata,
    output logic [NUM_PORTS-1:0]           req_resp,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_BITS-1:0]           mem_addr,
    output logic [BUS_BITS-1:0]            mem_wdata,
    input  logic [BUS_BITS-1:0]            mem_rdata,
    input  logic                           mem_resp
);

    localparam int BEATS    = LINE_BITS / BUS_BITS;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W    = $clog2(NUM_PORTS);
    localparam int OFF_BITS = $clog2(LINE_BITS / 8);

    localparam logic [ADDR_BITS-1:0] ADDR_MASK = {ADDR_BITS{1'b1}} << OFF_BITS;
    localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]     LAST_PORT = IDX_W'(NUM_PORTS - 1);
    localparam logic [IDX_W:0]       NP_W      = (IDX_W + 1)'(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant;
    logic                 is_write;
    // Holds the write line during write bursts and the partially assembled line during reads.
    logic [LINE_BITS-1:0] line_buf;

    logic [NUM_PORTS-1:0] pending;
    logic [IDX_W-1:0]     scan_base;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W:0]       idx;
    logic                 found;
    logic [LINE_BITS-1:0] asm_line;
    logic [CNT_W-1:0]     nxt;
    logic                 last_beat;

    assign pending   = req_read | req_write;
    assign scan_base = (PRIO_MODE == 1) ? '0 : rr_ptr;
    assign nxt       = cnt + 1'b1;
    assign last_beat = (cnt == LAST_BEAT);

    // First requesting port scanning upward from scan_base, wrapping modulo NUM_PORTS.
    always_comb begin
        sel   = scan_base;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = {1'b0, scan_base} + (IDX_W + 1)'(k);
            if (idx >= NP_W) begin
                idx = idx - NP_W;
            end
            if (!found && pending[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[IDX_W-1:0];
            end
        end
    end

    // Line buffer with the incoming beat merged into the current slot.
    always_comb begin
        asm_line = line_buf;
        asm_line[cnt*BUS_BITS +: BUS_BITS] = mem_rdata;
    end

    // Arbitration / burst FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            is_write  <= 1'b0;
            line_buf  <= '0;
            req_rdata <= '0;
            req_resp  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state     <= BURST;
                        grant     <= sel;
                        is_write  <= req_write[sel];
                        cnt       <= '0;
                        mem_addr  <= req_addr[sel*ADDR_BITS +: ADDR_BITS] & ADDR_MASK;
                        line_buf  <= req_wdata[sel*LINE_BITS +: LINE_BITS];
                        mem_wdata <= req_wdata[sel*LINE_BITS +: BUS_BITS];
                        mem_read  <= ~req_write[sel];
                        mem_write <= req_write[sel];
                    end
                end
                BURST: begin
                    if (mem_resp) begin
                        if (is_write) begin
                            if (!last_beat) begin
                                mem_wdata <= line_buf[nxt*BUS_BITS +: BUS_BITS];
                            end
                        end else begin
                            line_buf <= asm_line;
                        end
                        if (last_beat) begin
                            state     <= DONE;
                            mem_read  <= 1'b0;
                            mem_write <= 1'b0;
                            req_resp  <= NUM_PORTS'(1) << grant;
                            if (!is_write) begin
                                req_rdata <= asm_line;
                            end
                        end else begin
                            cnt <= nxt;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    req_resp <= '0;
                    if (PRIO_MODE == 0) begin
                        rr_ptr <= (grant == LAST_PORT) ? '0 : grant + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// tb_pmem_line_arbiter: randomized and directed checks of two arbiter instances (round-robin, fixed priority).
// Latency: bench drives one transaction at a time and expects resp exactly one cycle after the last beat.
// Backpressure: bench memory inserts fixed or random wait cycles before each beat.
module tb_pmem_line_arbiter;

    localparam int NP    = 3;
    localparam int LB    = 256;
    localparam int BB    = 64;
    localparam int AB    = 32;
    localparam int BEATS = LB / BB;
    localparam int OFF   = $clog2(LB / 8);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // fp selects which instance is exercised: 0 round-robin, 1 fixed priority.
    logic             fp;
    logic [NP-1:0]    cur_rd, cur_wr;
    logic [NP*AB-1:0] cur_addr;
    logic [NP*LB-1:0] cur_wdata;
    logic             cur_mresp;
    logic [BB-1:0]    cur_mrdata;

    logic [NP-1:0] a_rd, a_wr, b_rd, b_wr;
    logic          a_mresp, b_mresp;
    logic [LB-1:0] a_rdata, b_rdata;
    logic [NP-1:0] a_resp, b_resp;
    logic          a_mread, b_mread, a_mwrite, b_mwrite;
    logic [AB-1:0] a_maddr, b_maddr;
    logic [BB-1:0] a_mwdata, b_mwdata;

    assign a_rd    = fp ? '0 : cur_rd;
    assign a_wr    = fp ? '0 : cur_wr;
    assign b_rd    = fp ? cur_rd : '0;
    assign b_wr    = fp ? cur_wr : '0;
    assign a_mresp = fp ? 1'b0 : cur_mresp;
    assign b_mresp = fp ? cur_mresp : 1'b0;

    wire [LB-1:0] o_rdata  = fp ? b_rdata  : a_rdata;
    wire [NP-1:0] o_resp   = fp ? b_resp   : a_resp;
    wire          o_mread  = fp ? b_mread  : a_mread;
    wire          o_mwrite = fp ? b_mwrite : a_mwrite;
    wire [AB-1:0] o_maddr  = fp ? b_maddr  : a_maddr;
    wire [BB-1:0] o_mwdata = fp ? b_mwdata : a_mwdata;

    pmem_line_arbiter #(.NUM_PORTS(NP), .LINE_BITS(LB), .BUS_BITS(BB), .ADDR_BITS(AB), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .req_read(a_rd), .req_write(a_wr), .req_addr(cur_addr),
        .req_wdata(cur_wdata), .req_rdata(a_rdata), .req_resp(a_resp), .mem_read(a_mread),
        .mem_write(a_mwrite), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(cur_mrdata),
        .mem_resp(a_mresp));

    pmem_line_arbiter #(.NUM_PORTS(NP), .LINE_BITS(LB), .BUS_BITS(BB), .ADDR_BITS(AB), .PRIO_MODE(1)) u_fp (
        .clk(clk), .rst(rst), .req_read(b_rd), .req_write(b_wr), .req_addr(cur_addr),
        .req_wdata(cur_wdata), .req_rdata(b_rdata), .req_resp(b_resp), .mem_read(b_mread),
        .mem_write(b_mwrite), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(cur_mrdata),
        .mem_resp(b_mresp));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: memory image indexed by line, round-robin pointer, last read line.
    logic [LB-1:0] mem_m [8];
    logic [LB-1:0] last_rd_m;
    int            rr_m;
    int            rereq_pct;
    int            new_pct;

    function automatic int pick(input logic [NP-1:0] pend, input logic fixed, input int rr);
        for (int k = 0; k < NP; k++) begin
            int p;
            p = fixed ? k : (rr + k) % NP;
            if (pend[p]) return p;
        end
        return 0;
    endfunction

    task automatic new_req(input int p);
        int k;
        k = $urandom_range(0, 3);
        cur_rd[p] = (k != 2);
        cur_wr[p] = (k >= 2);
        cur_addr[p*AB +: AB] = $urandom & 32'h0000_ffff;
        for (int j = 0; j < LB / 32; j++) cur_wdata[p*LB + j*32 +: 32] = $urandom;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rdata"}, o_rdata, '0);
        check_eq({tag, "_resp"}, o_resp, '0);
        check_eq({tag, "_mread"}, o_mread, 1'b0);
        check_eq({tag, "_mwrite"}, o_mwrite, 1'b0);
        check_eq({tag, "_maddr"}, o_maddr, '0);
        check_eq({tag, "_mwdata"}, o_mwdata, '0);
    endtask

    // Called in an IDLE cycle with requests already driven; waits < 0 means random waits per beat.
    task automatic do_txn(input int waits);
        int            g, w, li;
        logic          wr;
        logic [AB-1:0] ea;
        logic [LB-1:0] line;
        logic [NP-1:0] oh;
        g    = pick(cur_rd | cur_wr, fp, rr_m);
        wr   = cur_wr[g];
        ea   = cur_addr[g*AB +: AB] & ~((32'd1 << OFF) - 32'd1);
        li   = int'(ea[7:5]);
        line = wr ? cur_wdata[g*LB +: LB] : mem_m[li];
        oh   = '0;
        oh[g] = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < BEATS; b++) begin
            w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
            for (int i = 0; i <= w; i++) begin
                check_eq("burst_mread", o_mread, !wr);
                check_eq("burst_mwrite", o_mwrite, wr);
                check_eq("burst_maddr", o_maddr, ea);
                if (wr) check_eq("burst_mwdata", o_mwdata, line[b*BB +: BB]);
                check_eq("burst_resp", o_resp, '0);
                cur_mresp  = (i == w);
                cur_mrdata = wr ? {$urandom, $urandom} : line[b*BB +: BB];
                @(posedge clk); #1;
                cur_mresp = 1'b0;
            end
        end
        check_eq("done_resp", o_resp, oh);
        check_eq("done_mread", o_mread, 1'b0);
        check_eq("done_mwrite", o_mwrite, 1'b0);
        if (wr) begin
            mem_m[li] = line;
        end else begin
            last_rd_m = line;
        end
        check_eq("done_rdata", o_rdata, last_rd_m);
        if (!fp) rr_m = (g + 1) % NP;
        if (int'($urandom_range(0, 99)) < rereq_pct) begin
            new_req(g);
        end else begin
            cur_rd[g] = 1'b0;
            cur_wr[g] = 1'b0;
        end
        for (int p = 0; p < NP; p++) begin
            if (p != g && !(cur_rd[p] | cur_wr[p]) && int'($urandom_range(0, 99)) < new_pct) new_req(p);
        end
        @(posedge clk); #1;
        check_eq("idle_resp", o_resp, '0);
        check_eq("idle_mread", o_mread, 1'b0);
        check_eq("idle_mwrite", o_mwrite, 1'b0);
    endtask

    task automatic random_phase(input int n);
        for (int t = 0; t < n; t++) begin
            if ((cur_rd | cur_wr) == '0) begin
                @(posedge clk); #1;
                check_eq("quiet_resp", o_resp, '0);
                check_eq("quiet_mread", o_mread | o_mwrite, 1'b0);
                new_req(int'($urandom_range(0, NP - 1)));
            end else begin
                do_txn(-1);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        fp         = 1'b0;
        cur_rd     = '0;
        cur_wr     = '0;
        cur_addr   = '0;
        cur_wdata  = '0;
        cur_mresp  = 1'b0;
        cur_mrdata = '0;
        rr_m       = 0;
        last_rd_m  = '0;
        rereq_pct  = 0;
        new_pct    = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < LB / 32; j++) mem_m[i][j*32 +: 32] = $urandom;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("rst_rr");
        fp = 1'b1;
        #1;
        check_outputs_zero("rst_fp");
        fp = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Single read on port 1 with zero-wait memory.
        mem_m[1] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        cur_rd[1] = 1'b1;
        cur_addr[1*AB +: AB] = 32'h0000_1234;
        do_txn(0);
        check_eq("tp_read_line", o_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Write beat order on port 0; read line must remain.
        cur_wr[0] = 1'b1;
        cur_addr[0 +: AB] = 32'h0000_0040;
        cur_wdata[0 +: LB] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        do_txn(0);

        // Three wait cycles before every beat.
        cur_rd[2] = 1'b1;
        cur_addr[2*AB +: AB] = 32'h0000_00a7;
        do_txn(3);

        // Move the round-robin pointer off zero before the reset test.
        cur_wr[1] = 1'b1;
        cur_addr[1*AB +: AB] = 32'h0000_0061;
        do_txn(0);

        // Reset after two beats of a read: everything clears at once and no resp follows.
        cur_rd[2] = 1'b1;
        cur_addr[2*AB +: AB] = 32'h0000_0020;
        @(posedge clk); #1;
        cur_mresp  = 1'b1;
        cur_mrdata = 64'hdead_beef_0000_0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cur_mresp = 1'b0;
        check_eq("pre_rst_mread", o_mread, 1'b1);
        rst = 1'b0;
        #1;
        check_outputs_zero("midrst");
        cur_rd = '0;
        cur_wr = '0;
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("midrst_resp", o_resp, '0);
        end
        rst = 1'b1;
        rr_m = 0;
        last_rd_m = '0;
        @(posedge clk); #1;
        check_eq("post_rst_resp", o_resp, '0);
        check_eq("post_rst_mread", o_mread, 1'b0);

        // All ports requesting continuously: rotation restarts at port 0.
        rereq_pct = 100;
        new_pct   = 100;
        for (int p = 0; p < NP; p++) new_req(p);
        repeat (6) do_txn(-1);

        // Random round-robin traffic.
        rereq_pct = 60;
        new_pct   = 40;
        random_phase(120);
        while ((cur_rd | cur_wr) != '0) begin
            rereq_pct = 0;
            new_pct   = 0;
            do_txn(-1);
        end

        // Fixed priority: port 0 keeps re-requesting, then drops; port 1 follows.
        fp = 1'b1;
        last_rd_m = '0;
        rereq_pct = 100;
        new_pct   = 0;
        new_req(0);
        new_req(1);
        repeat (3) do_txn(0);
        rereq_pct = 0;
        do_txn(0);
        do_txn(-1);

        // Random fixed-priority traffic.
        rereq_pct = 60;
        new_pct   = 50;
        random_phase(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
